// File: rtl/score_inject_ctrl.sv
// rtl/score_inject_ctrl.sv - button hit qualifier, pending-hit counter and r30 write-port injection mux; optional HIT_LOCKOUT_EN
module score_inject_ctrl #(
    parameter int STATUS_REG  = 30,
    parameter int PEND_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCKOUT_CYC = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_in,
    input  logic              light_on,
    input  logic              proc_we,
    input  logic [4:0]        proc_rd,
    input  logic [31:0]       proc_data,
    input  logic [31:0]       rstatus,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              hit_pulse,
    output logic [PEND_W-1:0] pending,
    output logic              inject_busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SLOT,
        WAIT_ACK
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t                   state_q;
    state_t                   state_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     sync_out;
    logic                     hist_q;
    logic                     edge_qual;
    logic                     hit_ok;
    logic                     hit_q;
    logic [PEND_W-1:0]        pend_q;
    logic                     pend_inc;
    logic                     inject;

    // Button is idle-high; reset state avoids a phantom edge on release.
    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign edge_qual = hist_q & ~sync_out & light_on;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
            hist_q <= sync_out;
        end
    end

`ifdef HIT_LOCKOUT_EN
    localparam int LOCK_W = $clog2(LOCKOUT_CYC + 1);

    logic [LOCK_W-1:0] lock_cnt;

    // History keeps following the button during lockout, so a held press never fires late.
    assign hit_ok = edge_qual && (lock_cnt == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            lock_cnt <= '0;
        end else if (hit_q) begin
            lock_cnt <= LOCK_W'(LOCKOUT_CYC);
        end else if (lock_cnt != '0) begin
            lock_cnt <= lock_cnt - LOCK_W'(1);
        end
    end
`else
    assign hit_ok = edge_qual;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_ok;
        end
    end

    assign pend_inc = hit_q && (pend_q != PEND_MAX);

    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_q <= '0;
        end else if (inject) begin
            pend_q <= pend_inc ? PEND_W'(1) : '0;
        end else if (pend_inc) begin
            pend_q <= pend_q + PEND_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Injection only claims cycles the processor leaves idle; pending is nonzero in WAIT_SLOT.
    always_comb begin
        state_d = state_q;
        inject  = 1'b0;
        case (state_q)
            IDLE: begin
                if ((pend_q != '0) && (rstatus == 32'd0)) begin
                    state_d = WAIT_SLOT;
                end
            end
            WAIT_SLOT: begin
                if (!proc_we && reset) begin
                    inject  = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (rstatus == 32'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_we   = proc_we;
        wb_rd   = proc_rd;
        wb_data = proc_data;
        if (inject) begin
            wb_we   = 1'b1;
            wb_rd   = 5'(STATUS_REG);
            wb_data = 32'(pend_q);
        end
        if (!reset) begin
            wb_we = 1'b0;
        end
    end

    assign hit_pulse   = hit_q;
    assign pending     = pend_q;
    assign inject_busy = (state_q == WAIT_ACK);

endmodule

// File: tb/tb_score_inject_ctrl.sv
// tb/tb_score_inject_ctrl.sv - scoreboard bench for score_inject_ctrl
module tb_score_inject_ctrl;

    logic        clock;
    logic        reset;
    logic        btn_in;
    logic        light_on;
    logic        proc_we;
    logic [4:0]  proc_rd;
    logic [31:0] proc_data;
    logic [31:0] rstatus;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        hit_pulse;
    logic [7:0]  pending;
    logic        inject_busy;

    int checks;
    int errors;
    int hit_count;
    int inj_count;
    logic [31:0] exp_q[$];
    logic [31:0] r30 = '0;
    logic        sw_clear;

    score_inject_ctrl #(
        .STATUS_REG(30),
        .PEND_W(8),
        .SYNC_STAGES(2),
        .LOCKOUT_CYC(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn_in(btn_in),
        .light_on(light_on),
        .proc_we(proc_we),
        .proc_rd(proc_rd),
        .proc_data(proc_data),
        .rstatus(rstatus),
        .wb_we(wb_we),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .hit_pulse(hit_pulse),
        .pending(pending),
        .inject_busy(inject_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Regfile model for r30: commits the muxed write port, software clears on request.
    always @(posedge clock) begin
        if (sw_clear) r30 <= '0;
        else if (wb_we && wb_rd == 5'd30) r30 <= wb_data;
    end
    assign rstatus = r30;

    always @(negedge clock) begin
        if (hit_pulse === 1'b1) hit_count++;
        if (reset && proc_we) begin
            checks++;
            if (wb_we !== 1'b1 || wb_rd !== proc_rd || wb_data !== proc_data) begin
                errors++;
                $display("FAIL passthrough: wb %b/%0d/%h required %b/%0d/%h", wb_we, wb_rd, wb_data, 1'b1, proc_rd, proc_data);
            end
        end
        if (reset && !proc_we && wb_we === 1'b1) begin
            inj_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_inject: wb_rd=%0d wb_data=%0d required no write", wb_rd, wb_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (wb_rd !== 5'd30 || wb_data !== e) begin
                    errors++;
                    $display("FAIL inject_data: wb_rd=%0d wb_data=%0d required rd=30 data=%0d", wb_rd, wb_data, e);
                end
            end
        end
    end

    task automatic do_hit();
        btn_in = 1'b0;
        repeat (3) @(posedge clock);
        #1 btn_in = 1'b1;
        repeat (19) @(posedge clock);
        #1;
    endtask

    task automatic pulse_clear();
        sw_clear = 1'b1;
        @(posedge clock);
        #1 sw_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; btn_in = 1'b1; light_on = 1'b1;
        proc_we = 1'b1; proc_rd = 5'd4; proc_data = 32'h1234_5678; sw_clear = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (wb_we !== 1'b0 || hit_pulse !== 1'b0 || pending !== 8'd0 || inject_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: we=%b hit=%b pend=%0d busy=%b required 0/0/0/0", wb_we, hit_pulse, pending, inject_busy);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic test_hit_latency();
        btn_in = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            @(negedge clock);
            checks++;
            if (hit_pulse !== (k == 3)) begin
                errors++;
                $display("FAIL hit_latency cycle %0d: hit_pulse=%b required %b", k, hit_pulse, (k == 3));
            end
        end
        checks++;
        if (pending !== 8'd1) begin
            errors++;
            $display("FAIL pending_after_hit: %0d required 1", pending);
        end
        btn_in = 1'b1;
        repeat (19) @(posedge clock);
        #1;
    endtask

    task automatic test_inject_slot();
        repeat (5) begin
            proc_data = $urandom;
            @(posedge clock);
            #1;
        end
        exp_q.push_back(32'd1);
        proc_we = 1'b0;
        @(negedge clock);
        checks++;
        if (wb_we !== 1'b1 || wb_rd !== 5'd30 || wb_data !== 32'd1) begin
            errors++;
            $display("FAIL first_inject: %b/%0d/%0d required 1/30/1", wb_we, wb_rd, wb_data);
        end
        @(posedge clock);
        #1 proc_we = 1'b1;
        checks++;
        if (pending !== 8'd0 || inject_busy !== 1'b1) begin
            errors++;
            $display("FAIL after_inject: pend=%0d busy=%b required 0/1", pending, inject_busy);
        end
    endtask

    task automatic test_wait_ack_accumulate();
        int i0;
        i0 = inj_count;
        repeat (3) do_hit();
        checks++;
        if (pending !== 8'd3 || inject_busy !== 1'b1 || inj_count != i0) begin
            errors++;
            $display("FAIL wait_ack_hold: pend=%0d busy=%b inj=%0d required 3/1/%0d", pending, inject_busy, inj_count, i0);
        end
        exp_q.push_back(32'd3);
        proc_we = 1'b0;
        pulse_clear();
        for (int c = 0; c < 10 && inj_count == i0; c++) @(posedge clock);
        #1 proc_we = 1'b1;
        checks++;
        if (inj_count != i0 + 1) begin
            errors++;
            $display("FAIL reinject_timeout: injections=%0d required %0d", inj_count - i0, 1);
        end
        checks++;
        if (pending !== 8'd0 || inject_busy !== 1'b1) begin
            errors++;
            $display("FAIL after_reinject: pend=%0d busy=%b required 0/1", pending, inject_busy);
        end
    endtask

    task automatic test_same_cycle_hit();
        repeat (2) do_hit();
        pulse_clear();
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (inject_busy !== 1'b0 || pending !== 8'd2) begin
            errors++;
            $display("FAIL wait_slot: busy=%b pend=%0d required 0/2", inject_busy, pending);
        end
        exp_q.push_back(32'd2);
        btn_in = 1'b0;
        repeat (3) @(posedge clock);
        #1 proc_we = 1'b0;
        @(negedge clock);
        checks++;
        if (hit_pulse !== 1'b1 || wb_we !== 1'b1 || wb_data !== 32'd2) begin
            errors++;
            $display("FAIL same_cycle_inject: hit=%b we=%b data=%0d required 1/1/2", hit_pulse, wb_we, wb_data);
        end
        @(posedge clock);
        #1 proc_we = 1'b1;
        btn_in = 1'b1;
        checks++;
        if (pending !== 8'd1 || inject_busy !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_pending: pend=%0d busy=%b required 1/1", pending, inject_busy);
        end
        repeat (19) @(posedge clock);
        #1;
    endtask

    task automatic test_saturation();
        int i0;
        i0 = inj_count;
        repeat (300) do_hit();
        checks++;
        if (pending !== 8'd255 || inj_count != i0) begin
            errors++;
            $display("FAIL saturate: pend=%0d inj=%0d required 255/%0d", pending, inj_count, i0);
        end
        exp_q.push_back(32'd255);
        proc_we = 1'b0;
        pulse_clear();
        for (int c = 0; c < 10 && inj_count == i0; c++) @(posedge clock);
        #1 proc_we = 1'b1;
        checks++;
        if (inj_count != i0 + 1) begin
            errors++;
            $display("FAIL saturate_inject_timeout: injections=%0d required %0d", inj_count - i0, 1);
        end
    endtask

    task automatic test_light_off();
        int h0;
        logic [7:0] p0;
        h0 = hit_count;
        p0 = pending;
        light_on = 1'b0;
        do_hit();
        checks++;
        if (hit_count != h0 || pending !== p0) begin
            errors++;
            $display("FAIL light_off: hits=%0d pend=%0d required %0d/%0d", hit_count - h0, pending, 0, p0);
        end
        btn_in = 1'b0;
        repeat (6) @(posedge clock);
        #1 light_on = 1'b1;
        repeat (6) @(posedge clock);
        #1 btn_in = 1'b1;
        repeat (19) @(posedge clock);
        #1;
        checks++;
        if (hit_count != h0 || pending !== p0) begin
            errors++;
            $display("FAIL light_late_on: hits=%0d pend=%0d required %0d/%0d", hit_count - h0, pending, 0, p0);
        end
    endtask

    task automatic test_back_to_back();
        int h0;
        int want;
        logic [7:0] p0;
        h0 = hit_count;
        p0 = pending;
`ifdef HIT_LOCKOUT_EN
        want = 1;
`else
        want = 2;
`endif
        btn_in = 1'b0; repeat (2) @(posedge clock);
        #1 btn_in = 1'b1; repeat (3) @(posedge clock);
        #1 btn_in = 1'b0; repeat (3) @(posedge clock);
        #1 btn_in = 1'b1; repeat (25) @(posedge clock);
        #1;
        checks++;
        if (hit_count - h0 != want || pending !== p0 + 8'(want)) begin
            errors++;
            $display("FAIL presses_5_apart: hits=%0d pend=%0d required %0d/%0d", hit_count - h0, pending, want, p0 + 8'(want));
        end
        h0 = hit_count;
        p0 = pending;
        btn_in = 1'b0; repeat (3) @(posedge clock);
        #1 btn_in = 1'b1; repeat (17) @(posedge clock);
        #1 btn_in = 1'b0; repeat (3) @(posedge clock);
        #1 btn_in = 1'b1; repeat (25) @(posedge clock);
        #1;
        checks++;
        if (hit_count - h0 != 2 || pending !== p0 + 8'd2) begin
            errors++;
            $display("FAIL presses_20_apart: hits=%0d pend=%0d required %0d/%0d", hit_count - h0, pending, 2, p0 + 8'd2);
        end
    endtask

    task automatic test_mid_reset();
        int i0;
        pulse_clear();
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (inject_busy !== 1'b0 || pending === 8'd0) begin
            errors++;
            $display("FAIL pre_reset_slot: busy=%b pend=%0d required 0/nonzero", inject_busy, pending);
        end
        i0 = inj_count;
        reset = 1'b0;
        proc_we = 1'b0;
        @(negedge clock);
        checks++;
        if (wb_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_mux: wb_we=%b required 0", wb_we);
        end
        @(posedge clock);
        #1;
        checks++;
        if (pending !== 8'd0 || inject_busy !== 1'b0 || hit_pulse !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: pend=%0d busy=%b hit=%b required 0/0/0", pending, inject_busy, hit_pulse);
        end
        reset = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        checks++;
        if (inj_count != i0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: inj=%0d queued=%0d required 0/0", inj_count - i0, exp_q.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hit_count = 0;
        inj_count = 0;
        test_reset();
        test_hit_latency();
        test_inject_slot();
        test_wait_ack_accumulate();
        test_same_cycle_hit();
        test_saturation();
        test_light_off();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_inject_ctrl.md
Name: score_inject_ctrl

Overview:
- Upstream stage of the register-file write port in the game top.
- Converts raw button presses into qualified hits and accumulates them in a pending counter.
- Injects the pending count into the status register (r30) only during cycles when the processor is not writing.
- Holds off further injections until software has consumed r30, i.e. read it and cleared it to zero.

Parameters:
- STATUS_REG, 30: register index written on injection.
- PEND_W, 8: width of the pending-hit counter.
- SYNC_STAGES, 2: button synchronizer depth, minimum 2.
- LOCKOUT_CYC, 16: post-hit lockout length in cycles; used only when HIT_LOCKOUT_EN is defined.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- btn_in  in  1  raw button, asynchronous; 1 = released, 0 = pressed.
- light_on  in  1  target LED state; a press counts only while this is 1.
- proc_we  in  1  processor regfile write enable.
- proc_rd  in  5  processor regfile write index.
- proc_data  in  32  processor regfile write data.
- rstatus  in  32  current r30 contents, read back from the regfile.
- wb_we  out  1  regfile write enable after muxing.
- wb_rd  out  5  regfile write index after muxing.
- wb_data  out  32  regfile write data after muxing.
- hit_pulse  out  1  one-cycle strobe per qualified hit.
- pending  out  PEND_W  hits not yet injected.
- inject_busy  out  1  high while in WAIT_ACK.

Behaviour:
- Reset (reset==0 at a rising edge):
  - synchronizer flops set to 1; edge-detect history set to 1.
  - pending=0, FSM=IDLE, hit_pulse=0, inject_busy=0.
  - While reset==0, wb_we is forced 0.
- Hit detection:
  - btn_in passes through SYNC_STAGES flops, then one history flop.
  - hit_pulse is registered. It is 1 for exactly one cycle when the history flop holds 1, the synchronized value is 0, and light_on==1 in that same cycle.
  - Latency from a btn_in fall to hit_pulse high is SYNC_STAGES+1 cycles.
  - A falling edge while light_on==0 is discarded and not remembered.
- Pending counter:
  - Increments by 1 in the cycle after hit_pulse.
  - Saturates at 2^PEND_W-1; further hits are dropped.
- FSM states: IDLE, WAIT_SLOT, WAIT_ACK.
  - IDLE: go to WAIT_SLOT when pending!=0 and rstatus==0.
  - WAIT_SLOT: inject when proc_we==0; otherwise stay in WAIT_SLOT indefinitely.
  - Injection is combinational in the same cycle: wb_we=1, wb_rd=STATUS_REG, wb_data=zero-extended pending.
  - At that edge pending clears to 0, or to 1 if a hit increment lands in the same cycle, and the FSM goes to WAIT_ACK.
  - WAIT_ACK: inject_busy=1. The regfile commits the write at the injection edge, so rstatus is nonzero from the first WAIT_ACK cycle.
  - Leave WAIT_ACK for IDLE when rstatus==0, i.e. software has cleared r30.
  - Hits keep accumulating in every state.
- Write-port mux: in every cycle without an injection, wb_we/wb_rd/wb_data equal proc_we/proc_rd/proc_data exactly.
  - A processor write is never dropped or delayed.
  - The block never writes during a cycle where proc_we==1.
- Processor write to STATUS_REG: passes through unchanged.
  - Writing nonzero in IDLE with pending!=0 keeps the FSM in IDLE until r30 is zero again.
- Reset mid-operation: any state returns to IDLE; pending hits are lost.
  - The injection mux is released in the same cycle reset goes low.
- Pending value at injection: the injected value is never 0 and never exceeds 2^PEND_W-1.

Optional Feature:
- Macro: HIT_LOCKOUT_EN.
- Defined:
  - After each hit_pulse, a lockout counter loads LOCKOUT_CYC.
  - While the counter is nonzero, qualified edges are ignored and the counter decrements each cycle.
  - The history flop still tracks the synchronized button, so a press held through the lockout does not create a late hit.
  - Reset clears the counter.
- Undefined: no lockout counter and no lockout logic; every qualified edge produces a hit.

Test Plan:
- Reset release, light_on=1, btn_in pulled low for 3 cycles at cycle 10 -> hit_pulse high at exactly cycle 13; pending=1 at cycle 14.
- rstatus=0, pending=1, proc_we held at 1 for 5 cycles with proc_rd=4 -> wb follows proc for all 5 cycles. On the first cycle with proc_we=0: wb_we=1, wb_rd=30, wb_data=1. Next cycle: pending=0, inject_busy=1.
- In WAIT_ACK, 3 further hits arrive with rstatus held at 1 -> no injection and pending=3. Drive rstatus=0 -> IDLE, then WAIT_SLOT, then injection of wb_data=3.
- Hit in the same cycle as an injection of pending=2 -> wb_data=2 and pending=1 afterward.
- 300 hits with PEND_W=8 and rstatus stuck nonzero -> pending saturates at 255; later injection carries wb_data=255.
- btn_in falling edge with light_on=0 -> no hit_pulse and pending unchanged. With HIT_LOCKOUT_EN defined, two presses 5 cycles apart -> only 1 hit; presses 20 cycles apart -> 2 hits.
